// File: rtl/usb_pkg.sv
// Shared constants and types for the USB protocol controller.
package usb_pkg;

  // Token / handshake / data PIDs (4-bit form as seen on rx_packet).
  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidStall = 4'b1110;

  // Command issued to the tx module.
  typedef enum logic [1:0] {
    TxNone = 2'd0,
    TxData = 2'd1,
    TxAck  = 2'd2,
    TxNak  = 2'd3
  } tx_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWaitOutData,
    StIssue,
    StTxWaitStart,
    StTxWaitEnd,
    StWaitHostAck
  } state_e;

  localparam int unsigned TimerWidth     = 8;
  // Host reply / OUT data timeout, in cycles spent in the waiting state.
  localparam int unsigned TIMEOUT_CYCLES = 160;
  // Last counter value in TX_WAIT_START before giving up on the tx module.
  localparam int unsigned TxStartLimit   = 2;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PidData0) || (pid == PidData1);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with synchronous clear and terminal-count flag.
module timeout_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] term_i,
  output logic             flag_o
);

  logic [Width-1:0] count_q, count_d;

  // Count while enabled, hold at the terminal value (never wraps).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != term_i)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign flag_o = (count_q == term_i);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB device-side transaction sequencer: decodes received PIDs, commands the
// tx module, and watches for host/tx timeouts. All outputs are registered.
module usb_protocol_ctrl
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       data_pending,
  output logic [1:0] tx_packet,
  output logic       d_mode,
  output logic       rx_done,
  output logic       tx_done,
  output logic       proto_error,
  output logic       clear_buffer
);

  state_e  state_q, state_d;
  tx_cmd_e cmd_q, cmd_d;
  tx_cmd_e tx_packet_q, tx_packet_d;
  logic    d_mode_q, d_mode_d;
  logic    rx_done_q, rx_done_d;
  logic    tx_done_q, tx_done_d;
  logic    proto_error_q, proto_error_d;
  logic    clear_buffer_q, clear_buffer_d;

  logic                  timer_clr, timer_en, timer_flag;
  logic [TimerWidth-1:0] timer_term;

  timeout_counter #(
    .Width (TimerWidth)
  ) u_timeout_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .term_i (timer_term),
    .flag_o (timer_flag)
  );

  // Next-state, command and pulse decode; outputs are derived from the next state.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    rx_done_d      = 1'b0;
    tx_done_d      = 1'b0;
    proto_error_d  = 1'b0;
    clear_buffer_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_data_ready && !rx_error) begin
          if (rx_packet == PidIn) begin
            state_d = StIssue;
            cmd_d   = (data_pending && (buffer_occupancy != '0)) ? TxData : TxNak;
          end else if (rx_packet == PidOut) begin
            state_d = StWaitOutData;
          end
        end
      end
      StWaitOutData: begin
        // A packet arriving in the timeout cycle takes precedence.
        if (rx_data_ready) begin
          if (!rx_error && is_data_pid(rx_packet)) begin
            rx_done_d = 1'b1;
            cmd_d     = TxAck;
            state_d   = StIssue;
          end else begin
            proto_error_d  = 1'b1;
            clear_buffer_d = 1'b1;
            state_d        = StIdle;
          end
        end else if (timer_flag) begin
          proto_error_d  = 1'b1;
          clear_buffer_d = 1'b1;
          state_d        = StIdle;
        end
      end
      StIssue: begin
        state_d = StTxWaitStart;
      end
      StTxWaitStart: begin
        if (tx_error) begin
          proto_error_d = 1'b1;
          state_d       = StIdle;
        end else if (tx_transfer_active) begin
          state_d = StTxWaitEnd;
        end else if (timer_flag) begin
          proto_error_d = 1'b1;
          state_d       = StIdle;
        end
      end
      StTxWaitEnd: begin
        if (tx_error) begin
          proto_error_d = 1'b1;
          state_d       = StIdle;
        end else if (!tx_transfer_active) begin
          state_d = (cmd_q == TxData) ? StWaitHostAck : StIdle;
        end
      end
      StWaitHostAck: begin
        if (rx_data_ready) begin
          if (!rx_error && (rx_packet == PidAck)) begin
            tx_done_d = 1'b1;
          end else begin
            proto_error_d = 1'b1;
          end
          state_d = StIdle;
        end else if (timer_flag) begin
          proto_error_d = 1'b1;
          state_d       = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    timer_en   = state_q inside {StWaitOutData, StTxWaitStart, StWaitHostAck};
    timer_clr  = (state_d != state_q) &&
                 (state_d inside {StWaitOutData, StTxWaitStart, StWaitHostAck});
    timer_term = (state_q == StTxWaitStart) ? TimerWidth'(TxStartLimit)
                                            : TimerWidth'(TIMEOUT_CYCLES);

    tx_packet_d = (state_d == StIssue) ? cmd_d : TxNone;
    d_mode_d    = state_d inside {StIssue, StTxWaitStart, StTxWaitEnd};
  end

  // State, command and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cmd_q          <= TxNone;
      tx_packet_q    <= TxNone;
      d_mode_q       <= 1'b0;
      rx_done_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      proto_error_q  <= 1'b0;
      clear_buffer_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      tx_packet_q    <= tx_packet_d;
      d_mode_q       <= d_mode_d;
      rx_done_q      <= rx_done_d;
      tx_done_q      <= tx_done_d;
      proto_error_q  <= proto_error_d;
      clear_buffer_q <= clear_buffer_d;
    end
  end

  assign tx_packet    = tx_packet_q;
  assign d_mode       = d_mode_q;
  assign rx_done      = rx_done_q;
  assign tx_done      = tx_done_q;
  assign proto_error  = proto_error_q;
  assign clear_buffer = clear_buffer_q;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Randomised + directed bench for usb_protocol_ctrl against a transaction-rule model.
module tb_usb_protocol_ctrl;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Transaction phases of the reference model.
  localparam int PhIdle = 0, PhOutData = 1, PhIssue = 2, PhTxStart = 3, PhTxEnd = 4,
                 PhHostAck = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rx_packet;
  logic       rx_data_ready, rx_error, tx_transfer_active, tx_error, data_pending;
  logic [6:0] buffer_occupancy;
  logic [1:0] tx_packet;
  logic       d_mode, rx_done, tx_done, proto_error, clear_buffer;

  int total = 0;
  int bad = 0;

  // Model state and expected outputs after the next rising edge.
  int m_phase, m_cmd, m_wait;
  int e_txp, e_dm, e_rxd, e_txd, e_pe, e_cb;

  usb_protocol_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .rx_packet          (rx_packet),
    .rx_data_ready      (rx_data_ready),
    .rx_error           (rx_error),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .buffer_occupancy   (buffer_occupancy),
    .data_pending       (data_pending),
    .tx_packet          (tx_packet),
    .d_mode             (d_mode),
    .rx_done            (rx_done),
    .tx_done            (tx_done),
    .proto_error        (proto_error),
    .clear_buffer       (clear_buffer)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PhIdle; m_cmd = 0; m_wait = 0;
    e_txp = 0; e_dm = 0; e_rxd = 0; e_txd = 0; e_pe = 0; e_cb = 0;
  endtask

  // Apply the current inputs to the model: one clock of protocol behaviour.
  task automatic model_step();
    int nxt;
    nxt = m_phase;
    e_rxd = 0; e_txd = 0; e_pe = 0; e_cb = 0;
    case (m_phase)
      PhIdle: begin
        if (rx_data_ready && !rx_error) begin
          if (rx_packet == PID_IN) begin
            m_cmd = (data_pending && buffer_occupancy != 0) ? 1 : 3;
            nxt = PhIssue;
          end else if (rx_packet == PID_OUT) begin
            nxt = PhOutData; m_wait = 0;
          end
        end
      end
      PhOutData: begin
        if (rx_data_ready) begin
          if (!rx_error && (rx_packet == PID_DATA0 || rx_packet == PID_DATA1)) begin
            e_rxd = 1; m_cmd = 2; nxt = PhIssue;
          end else begin
            e_pe = 1; e_cb = 1; nxt = PhIdle;
          end
        end else if (m_wait == 160) begin
          e_pe = 1; e_cb = 1; nxt = PhIdle;
        end else m_wait++;
      end
      PhIssue: begin
        nxt = PhTxStart; m_wait = 0;
      end
      PhTxStart: begin
        if (tx_error) begin
          e_pe = 1; nxt = PhIdle;
        end else if (tx_transfer_active) nxt = PhTxEnd;
        else if (m_wait == 2) begin
          e_pe = 1; nxt = PhIdle;
        end else m_wait++;
      end
      PhTxEnd: begin
        if (tx_error) begin
          e_pe = 1; nxt = PhIdle;
        end else if (!tx_transfer_active) begin
          if (m_cmd == 1) begin
            nxt = PhHostAck; m_wait = 0;
          end else nxt = PhIdle;
        end
      end
      default: begin
        if (rx_data_ready) begin
          if (!rx_error && rx_packet == PID_ACK) e_txd = 1;
          else e_pe = 1;
          nxt = PhIdle;
        end else if (m_wait == 160) begin
          e_pe = 1; nxt = PhIdle;
        end else m_wait++;
      end
    endcase
    m_phase = nxt;
    e_txp = (m_phase == PhIssue) ? m_cmd : 0;
    e_dm = (m_phase == PhIssue || m_phase == PhTxStart || m_phase == PhTxEnd) ? 1 : 0;
  endtask

  // The single compare point: all outputs against the model each cycle.
  task automatic compare();
    check("tx_packet", tx_packet, e_txp);
    check("d_mode", d_mode, e_dm);
    check("rx_done", rx_done, e_rxd);
    check("tx_done", tx_done, e_txd);
    check("proto_error", proto_error, e_pe);
    check("clear_buffer", clear_buffer, e_cb);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    rx_packet = 4'b0000; rx_data_ready = 1'b0; rx_error = 1'b0;
    tx_transfer_active = 1'b0; tx_error = 1'b0; data_pending = 1'b0;
    buffer_occupancy = 7'd0;
  endtask

  task automatic rx(input logic [3:0] pid, input logic err);
    idle_in();
    rx_packet = pid; rx_data_ready = 1'b1; rx_error = err;
  endtask

  // Asynchronous reset; outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_in();
    #1;
    check({tag, "_txp"}, tx_packet, 0);
    check({tag, "_dmode"}, d_mode, 0);
    check({tag, "_perr"}, proto_error, 0);
    check({tag, "_pulses"}, {rx_done, tx_done, clear_buffer}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // IN with payload, tx active one cycle, ends in the host-ACK wait (wait count 0).
  task automatic in_data_to_host_wait();
    rx(PID_IN, 1'b0); data_pending = 1'b1; buffer_occupancy = 7'd8; cyc();
    idle_in(); cyc();
    tx_transfer_active = 1'b1; cyc();
    tx_transfer_active = 1'b0; cyc();
  endtask

  // Random tx agent state.
  int ag_delay = -1;
  int ag_len = 0;
  int quiet = 0;
  logic [3:0] pid_tab [10];

  initial begin
    pid_tab = '{PID_IN, PID_IN, PID_OUT, PID_OUT, PID_DATA0, PID_DATA1, PID_ACK, PID_ACK,
                PID_NAK, PID_STALL};
    rst = 1'b1;
    idle_in();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // IN with payload: DATA for one cycle, tx 3 cycles, host ACK.
    rx(PID_IN, 1'b0); data_pending = 1'b1; buffer_occupancy = 7'd8; cyc();
    check("t1_txp_data", tx_packet, 1);
    check("t1_dmode_issue", d_mode, 1);
    idle_in(); cyc();
    check("t1_txp_once", tx_packet, 0);
    tx_transfer_active = 1'b1; repeat (3) cyc();
    tx_transfer_active = 1'b0; cyc();
    check("t1_dmode_released", d_mode, 0);
    rx(PID_ACK, 1'b0); cyc();
    check("t1_tx_done", tx_done, 1);
    idle_in(); cyc();

    // IN with empty buffer: NAK, no tx_done.
    rx(PID_IN, 1'b0); data_pending = 1'b1; cyc();
    check("t2_txp_nak", tx_packet, 3);
    idle_in(); cyc();
    tx_transfer_active = 1'b1; cyc();
    tx_transfer_active = 1'b0; cyc();
    check("t2_dmode_idle", d_mode, 0);
    rx(PID_ACK, 1'b0); cyc();
    check("t2_no_tx_done", tx_done, 0);
    idle_in(); cyc();

    // OUT + DATA0 good: rx_done and ACK.
    rx(PID_OUT, 1'b0); cyc();
    idle_in(); cyc();
    rx(PID_DATA0, 1'b0); cyc();
    check("t3_rx_done", rx_done, 1);
    check("t3_txp_ack", tx_packet, 2);
    idle_in(); cyc();
    tx_transfer_active = 1'b1; cyc();
    tx_transfer_active = 1'b0; cyc();

    // OUT + DATA1 with rx error.
    rx(PID_OUT, 1'b0); cyc();
    rx(PID_DATA1, 1'b1); cyc();
    check("t4_perr", proto_error, 1);
    check("t4_clear", clear_buffer, 1);
    check("t4_no_txp", tx_packet, 0);
    idle_in(); cyc();
    check("t4_no_txp_after", tx_packet, 0);

    // Host silent: timeout after 160 full waiting cycles.
    in_data_to_host_wait();
    for (int i = 0; i < 160; i++) cyc();
    check("t5_no_early_timeout", proto_error, 0);
    cyc();
    check("t5_timeout", proto_error, 1);
    idle_in(); cyc();

    // ACK in the timeout cycle wins.
    in_data_to_host_wait();
    for (int i = 0; i < 160; i++) cyc();
    rx(PID_ACK, 1'b0); cyc();
    check("t6_ack_wins", tx_done, 1);
    check("t6_no_perr", proto_error, 0);
    idle_in(); cyc();

    // tx never starts: proto_error 4 cycles after ISSUE.
    rx(PID_IN, 1'b0); cyc();
    idle_in();
    repeat (3) cyc();
    check("t7_no_early_perr", proto_error, 0);
    cyc();
    check("t7_start_timeout", proto_error, 1);
    check("t7_dmode_off", d_mode, 0);
    cyc();

    // tx_error mid-transfer.
    rx(PID_IN, 1'b0); data_pending = 1'b1; buffer_occupancy = 7'd64; cyc();
    idle_in(); cyc();
    tx_transfer_active = 1'b1; cyc();
    check("t8_dmode_active", d_mode, 1);
    tx_error = 1'b1; cyc();
    check("t8_tx_error", proto_error, 1);
    check("t8_dmode_drop", d_mode, 0);
    idle_in(); cyc();

    // Reset while waiting for tx end, then a fresh IN.
    rx(PID_IN, 1'b0); data_pending = 1'b1; buffer_occupancy = 7'd3; cyc();
    idle_in(); cyc();
    tx_transfer_active = 1'b1; cyc();
    #2;
    do_reset("t9_mid_reset");
    rx(PID_IN, 1'b0); data_pending = 1'b1; buffer_occupancy = 7'd5; cyc();
    check("t9_after_reset", tx_packet, 1);
    idle_in(); cyc();
    check("t9_no_perr", proto_error, 0);

    // Randomised traffic with a reactive tx agent.
    for (int n = 0; n < 5000; n++) begin
      if (tx_packet != 2'd0) begin
        ag_delay = $urandom_range(0, 5);
        ag_len = $urandom_range(1, 4);
      end
      rx_packet = pid_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) rx_packet = 4'($urandom);
      if (quiet > 0) begin
        quiet--;
        rx_data_ready = 1'b0;
      end else begin
        rx_data_ready = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 199) == 0) quiet = $urandom_range(150, 175);
      end
      rx_error = ($urandom_range(0, 7) == 0);
      data_pending = ($urandom_range(0, 3) != 0);
      buffer_occupancy = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
      tx_error = ($urandom_range(0, 49) == 0);
      if (ag_delay > 0) begin
        ag_delay--;
        tx_transfer_active = 1'b0;
      end else if (ag_delay == 0) begin
        tx_transfer_active = 1'b1;
        ag_len--;
        if (ag_len == 0) ag_delay = -1;
      end else begin
        tx_transfer_active = 1'b0;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_protocol_ctrl.md
USB_PROTOCOL_CTRL -- requirements
Module: usb_protocol_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic rising-edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rx_packet  in  4  PID of the last received packet, valid when rx_data_ready=1.
REQ-004 SHALL have ports: rx_data_ready  in  1  1-cycle pulse, packet received.
REQ-005 SHALL have ports: rx_error  in  1  rx packet error, sampled with rx_data_ready.
REQ-006 SHALL have ports: tx_transfer_active  in  1  tx module is driving the bus.
REQ-007 SHALL have ports: tx_error  in  1  tx module aborted.
REQ-008 SHALL have ports: buffer_occupancy  in  7  shared data buffer byte count, 0..64.
REQ-009 SHALL have ports: data_pending  in  1  bus side has loaded an IN payload.
REQ-010 SHALL have ports: tx_packet  out  2  command to tx: 0 NONE, 1 DATA, 2 ACK, 3 NAK.
REQ-011 SHALL have ports: d_mode  out  1  1 while the USB line is owned by tx.
REQ-012 SHALL have ports: rx_done, tx_done, proto_error, clear_buffer  out  1 each  single-cycle status pulses.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_OUT_DATA, ISSUE, TX_WAIT_START, TX_WAIT_END, WAIT_HOST_ACK.
REQ-014 IDLE with rx_data_ready, rx_packet=IN(1001), data_pending=1, buffer_occupancy!=0: SHALL go to ISSUE with cmd=DATA.
REQ-015 IDLE with an IN that fails either condition in REQ-014: SHALL go to ISSUE with cmd=NAK.
REQ-016 IDLE with rx_data_ready, rx_packet=OUT(0001): SHALL go to WAIT_OUT_DATA and clear the timeout counter.
REQ-017 IDLE with any other PID (ACK, NAK, STALL, DATAx) or rx_error=1: SHALL ignore it and stay in IDLE.
REQ-018 WAIT_OUT_DATA, DATA0(0011)/DATA1(1011) without rx_error: SHALL pulse rx_done and go to ISSUE with cmd=ACK.
REQ-019 WAIT_OUT_DATA, rx_error=1, a non-DATA PID, or timeout: SHALL pulse proto_error and clear_buffer, then go to IDLE.
REQ-020 ISSUE SHALL drive tx_packet=cmd for exactly one cycle, then go to TX_WAIT_START; tx_packet SHALL be 0 in every other state.
REQ-021 TX_WAIT_START SHALL go to TX_WAIT_END on tx_transfer_active=1; if that does not occur within 4 cycles, SHALL pulse proto_error and go to IDLE.
REQ-022 TX_WAIT_END on tx_transfer_active falling SHALL go to WAIT_HOST_ACK if cmd=DATA, else to IDLE.
REQ-023 tx_error=1 in TX_WAIT_START or TX_WAIT_END SHALL pulse proto_error and go to IDLE; tx_error takes priority over tx_transfer_active in the same cycle.
REQ-024 WAIT_HOST_ACK, rx_data_ready with ACK(0010) and no rx_error: SHALL pulse tx_done and go to IDLE.
REQ-025 WAIT_HOST_ACK, any other packet, rx_error, or timeout: SHALL pulse proto_error and go to IDLE.
REQ-026 Timeout counter: 8-bit, cleared on entry to WAIT_OUT_DATA/WAIT_HOST_ACK, increments each cycle in those states; timeout SHALL fire when count = TIMEOUT_CYCLES (160); no wrap.
REQ-027 In the timeout cycle, an rx_data_ready arriving in the same cycle SHALL win over the timeout.
REQ-028 d_mode SHALL be 1 in ISSUE, TX_WAIT_START and TX_WAIT_END, and 0 otherwise.
REQ-029 All outputs SHALL be registered; the response to any event SHALL appear on the cycle after that event.

Reset
REQ-030 On rst=1 the block SHALL asynchronously enter IDLE with tx_packet=0, d_mode=0, all pulses 0, counter=0 and cmd=NONE.
REQ-031 Reset asserted mid-transfer SHALL abandon the transaction without asserting proto_error.

Structure
REQ-032 The PID constants, the tx_packet encoding, the FSM state enum and TIMEOUT_CYCLES SHALL live in shared package usb_pkg.
REQ-033 The timeout counter SHALL be sub-module timeout_counter (clear, enable, terminal count, flag).

Verification
REQ-034 IN, data_pending=1, occupancy=8 -> tx_packet=1 for one cycle, d_mode=1; tx active 3 cycles then ACK -> tx_done pulse, back to IDLE.
REQ-035 IN with occupancy=0 -> tx_packet=3 (NAK); after tx ends -> IDLE, no tx_done.
REQ-036 OUT then DATA0 with rx_error=0 -> rx_done pulse, tx_packet=2 (ACK); OUT then DATA1 with rx_error=1 -> proto_error and clear_buffer, no tx_packet.
REQ-037 DATA sent, no host reply for 160 cycles -> proto_error on timeout, IDLE; rx_data_ready ACK exactly on cycle 160 -> tx_done instead.
REQ-038 tx_transfer_active never rises -> proto_error 4 cycles after ISSUE; tx_error mid-transfer -> proto_error, d_mode=0 next cycle.
REQ-039 rst asserted during TX_WAIT_END -> all outputs 0 immediately; next IN is handled normally.
